pattern_frame_scheduler: RTL



---
 rtl/pattern_frame_scheduler.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/pattern_frame_scheduler.sv
// Round-robin scheduler sharing one thermometer-pattern serializer
// between NUM_REQ requesters; frames go out LSB-first, 8 bits each.
module pattern_frame_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                   clock,
  input  logic                   clear_n,
  input  logic                   en,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [3*NUM_REQ-1:0]   sel,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     done,
  output logic                   busy,
  output logic                   out_valid,
  output logic                   out_bit,
  output logic [2:0]             bit_idx
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    GAP
  } state_t;

  state_t       state;
  logic [2:0]   last;
  logic [2:0]   idx;
  logic [2:0]   cnt;
  logic [2:0]   gcnt;
  logic [7:0]   shreg;
  logic [7:0]   pat;

  logic               found;
  logic [2:0]         win;
  logic [2:0]         wsel;
  logic [NUM_REQ-1:0] wgnt;
  int                 best;
  int                 d;

  function automatic logic [7:0] thermo(input logic [2:0] s);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      p[i] = (3'(i) <= s);
    return p;
  endfunction

  assign pat = thermo(idx);

  // distance d from last_grant+1 ranks each requester; smallest wins
  always_comb begin
    found = 1'b0;
    win   = last;
    wsel  = '0;
    wgnt  = '0;
    best  = NUM_REQ;
    d     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      d = (i + NUM_REQ - 1 - int'(last)) % NUM_REQ;
      if (req[i] && d < best) begin
        best = d;
        win  = 3'(i);
        wsel = sel[3*i +: 3];
      end
    end
    found = (best < NUM_REQ);
    for (int i = 0; i < NUM_REQ; i++)
      wgnt[i] = found && (win == 3'(i));
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state     <= IDLE;
      gnt       <= '0;
      done      <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      bit_idx   <= '0;
      last      <= 3'(NUM_REQ - 1);
      idx       <= '0;
      cnt       <= '0;
      gcnt      <= '0;
      shreg     <= '0;
    end else begin
      done <= '0;
      unique case (state)
        IDLE: begin
          if (en && found) begin
            gnt   <= wgnt;
            idx   <= wsel;
            last  <= win;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          shreg     <= pat;
          cnt       <= '0;
          out_valid <= 1'b1;
          out_bit   <= pat[0];
          bit_idx   <= '0;
          state     <= SHIFT;
        end
        SHIFT: begin
          if (cnt == 3'd7) begin
            cnt       <= '0;
            bit_idx   <= '0;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            gnt       <= '0;
            gcnt      <= '0;
            if (GAP_CYCLES > 0) begin
              state <= GAP;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt     <= cnt + 3'd1;
            bit_idx <= cnt + 3'd1;
            out_bit <= shreg[cnt + 3'd1];
            // registered so the pulse lines up with bit 7
            if (cnt == 3'd6)
              done <= gnt;
          end
        end
        GAP: begin
          if (gcnt == 3'(GAP_CYCLES - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gcnt <= gcnt + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
